add_seq_ctrl: RTL and testbench
===============================

// Module: add_seq_ctrl
// PURPOSE
//   Sequencer that performs wide add/subtract by time-multiplexing one shared
//   4-bit adder slice (add_4bit family, with carry-in), one nibble per cycle,
//   LSB first, with the carry held in a register between nibbles.
//   Sits between an operand requester (valid/ready) and the adder slice; CPU
//   ALU ops wider than 4 bits are issued through this block.
// PARAMETERS
//   NIBBLES   4   operand width in nibbles (W = 4*NIBBLES); legal range >= 2
// PORTS
//   clk          in   1    rising-edge clock
//   rst_n        in   1    synchronous active-low reset
//   start_valid  in   1    request: operands valid
//   start_ready  out  1    block can accept a request (IDLE only)
//   a_in         in   W    operand A
//   b_in         in   W    operand B
//   sub_in       in   1    1 = A - B, 0 = A + B
//   add_a        out  4    nibble of A to adder slice
//   add_b        out  4    nibble of B (inverted when sub) to adder slice
//   add_cin      out  1    carry into adder slice
//   add_sum      in   4    combinational sum from adder slice, same cycle
//   add_cout     in   1    combinational carry from adder slice, same cycle
//   res_valid    out  1    result available
//   res_ready    in   1    consumer accepts result
//   result       out  W    sum/difference, mod 2^W
//   carry_out    out  1    final carry (sub: 1 = no borrow)
//   overflow     out  1    signed two's-complement overflow
//   busy         out  1    high in RUN or DONE
// BEHAVIOUR
// - Reset (rst_n=0 at an edge, any state, including mid-RUN): state=IDLE,
//   nibble index=0, carry reg=0. result, carry_out, overflow, res_valid = 0;
//   start_ready=1; busy=0. A partial operation is discarded, never reported.
// - FSM IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: start_ready=1. On an edge with start_valid=1, latch a_in,
//     b_in^{W{sub_in}} and sub_in. Set carry reg=sub_in, k=0, go to RUN.
//   - RUN: start_ready=0. Drive add_a=A[4k+3:4k], add_b=B'[4k+3:4k] and
//     add_cin=carry reg. At each edge, capture add_sum into result[4k+3:4k]
//     and add_cout into carry reg, then k=k+1.
//     - When k=NIBBLES-1 at the edge: also set carry_out=add_cout and compute
//       overflow = (A[W-1]==B'[W-1]) && (add_sum[3]!=A[W-1]). Go to DONE.
//     - k never wraps while in RUN.
//   - DONE: res_valid=1. result, carry_out and overflow are held stable.
//     On an edge with res_ready=1, go to IDLE and clear res_valid.
//     start_ready stays 0 in DONE, so there is no back-to-back overlap.
// - Latency: accept at edge E0; nibbles are captured at edges E1..E_NIBBLES;
//   res_valid=1 from E_NIBBLES onward. Minimum 1 idle cycle between ops.
// - Outside RUN, add_a, add_b and add_cin are driven 0.
// - start_valid while busy is ignored and not queued. Requester must hold
//   operands only until the accept edge.
// - result is cleared to 0 when a new request is accepted, not when
//   leaving DONE.
// - Arithmetic: mod 2^W. sub computes A + ~B + 1.
// TESTING (NIBBLES=4)
// - 16'h0003 + 16'h0001, res_ready=1 -> res_valid 4 cycles after accept,
//   result=16'h0004, carry_out=0, overflow=0.
// - 16'hFFFF + 16'h0001 -> result=16'h0000, carry_out=1, overflow=0;
//   check the carry ripples through every nibble.
// - 16'h7FFF + 16'h0001 -> result=16'h8000, overflow=1, carry_out=0;
//   then 16'h0005 - 16'h0007 (sub_in=1) -> result=16'hFFFE, carry_out=0.
// - Hold res_ready=0 for 10 cycles in DONE -> res_valid and result stable;
//   start_valid pulses ignored; start_ready=0 throughout.
// - Assert rst_n=0 at the 2nd RUN cycle -> next cycle IDLE, res_valid=0,
//   result=0, add_* = 0; a following 16'h1234 + 16'h1111 yields 16'h2345.
// - Scoreboard: 500 random a/b/sub ops with random res_ready stalls
//   -> result, carry_out and overflow match the reference model every time.

Source files
------------

// File: rtl/add_seq_ctrl.sv
// Wide add/subtract sequencer driving one shared 4-bit adder slice, one nibble per cycle,
// LSB first, with the inter-nibble carry held in a register.
module add_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start_valid,
    output logic                 o_start_ready,
    input  logic [4*NIBBLES-1:0] i_a_in,
    input  logic [4*NIBBLES-1:0] i_b_in,
    input  logic                 i_sub_in,
    output logic [3:0]           o_add_a,
    output logic [3:0]           o_add_b,
    output logic                 o_add_cin,
    input  logic [3:0]           i_add_sum,
    input  logic                 i_add_cout,
    output logic                 o_res_valid,
    input  logic                 i_res_ready,
    output logic [4*NIBBLES-1:0] o_result,
    output logic                 o_carry_out,
    output logic                 o_overflow,
    output logic                 o_busy
);

    // state  | meaning
    // IDLE   | ready for a request; adder inputs parked at 0
    // RUN    | one nibble per cycle through the shared slice
    // DONE   | result held until the consumer accepts it

    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [KW-1:0]   r_k;
    logic            r_carry;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_result;
    logic            r_carry_out;
    logic            r_overflow;

    logic            w_accept;
    logic            w_run;
    logic            w_last;
    logic [KW+1:0]   w_lo;

    assign w_run = (r_state == S_RUN);
    assign w_lo  = {r_k, 2'b00};

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_k == K_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (i_res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // B is stored already inverted for subtract so the slice only ever adds.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_k         <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            r_k         <= '0;
            r_carry     <= i_sub_in;
            r_a         <= i_a_in;
            r_b         <= i_b_in ^ {W{i_sub_in}};
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_run) begin
            r_result[w_lo +: 4] <= i_add_sum;
            r_carry             <= i_add_cout;
            if (w_last) begin
                r_carry_out <= i_add_cout;
                r_overflow  <= (r_a[W-1] == r_b[W-1]) && (i_add_sum[3] != r_a[W-1]);
            end else begin
                r_k <= r_k + 1'b1;
            end
        end
    end

    assign o_add_a       = w_run ? r_a[w_lo +: 4] : 4'd0;
    assign o_add_b       = w_run ? r_b[w_lo +: 4] : 4'd0;
    assign o_add_cin     = w_run ? r_carry : 1'b0;

    assign o_start_ready = (r_state == S_IDLE);
    assign o_res_valid   = (r_state == S_DONE);
    assign o_busy        = (r_state == S_RUN) || (r_state == S_DONE);
    assign o_result      = r_result;
    assign o_carry_out   = r_carry_out;
    assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl: directed cases plus a randomized scoreboard
// against plain (W+1)-bit arithmetic.
module tb_add_seq_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic          clk;
    logic          rst_n;
    logic          start_valid;
    logic          start_ready;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          sub_in;
    logic [3:0]    add_a;
    logic [3:0]    add_b;
    logic          add_cin;
    logic [3:0]    add_sum;
    logic          add_cout;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  result;
    logic          carry_out;
    logic          overflow;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    add_seq_ctrl #(.NIBBLES(NIB)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start_valid(start_valid),
        .o_start_ready(start_ready),
        .i_a_in       (a_in),
        .i_b_in       (b_in),
        .i_sub_in     (sub_in),
        .o_add_a      (add_a),
        .o_add_b      (add_b),
        .o_add_cin    (add_cin),
        .i_add_sum    (add_sum),
        .i_add_cout   (add_cout),
        .o_res_valid  (res_valid),
        .i_res_ready  (res_ready),
        .o_result     (result),
        .o_carry_out  (carry_out),
        .o_overflow   (overflow),
        .o_busy       (busy)
    );

    // behavioural 4-bit adder slice
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: whole-word arithmetic, overflow from operand/result signs
    task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                             output logic [W-1:0] r, output logic c, output logic o);
        logic [W:0] full;
        if (s) full = {1'b0, a} + {1'b0, ~b} + 1;
        else   full = {1'b0, a} + {1'b0, b};
        r = full[W-1:0];
        c = full[W];
        if (s) o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        else   o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    endtask

    // issue one request and wait (bounded) for res_valid; leaves the DUT in DONE
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output int lat, output logic [NIB-1:0] cins);
        for (int i = 0; i < 20 && !start_ready; i++) begin
            @(posedge clk); #1;
        end
        start_valid = 1'b1;
        a_in = a; b_in = b; sub_in = s;
        @(posedge clk); #1;
        start_valid = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom); sub_in = 1'($urandom);
        lat  = -1;
        cins = '0;
        for (int n = 1; n <= 20; n++) begin
            if (n <= NIB) cins[n-1] = add_cin;
            @(posedge clk); #1;
            if (res_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (start_ready !== 1'b1) begin failures++; $display("FAIL reset_start_ready got=%b exp=1", start_ready); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({result, carry_out, overflow} !== '0) begin failures++; $display("FAIL reset_result got=%h/%b/%b exp=0", result, carry_out, overflow); end
        checks++; if ({add_a, add_b, add_cin} !== 9'd0) begin failures++; $display("FAIL reset_add_io got=%h/%h/%b exp=0", add_a, add_b, add_cin); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int lat;
        logic [NIB-1:0] cins;
        logic [W-1:0] a [4] = '{16'h0003, 16'hFFFF, 16'h7FFF, 16'h0005};
        logic [W-1:0] b [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007};
        logic         s [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] er [4] = '{16'h0004, 16'h0000, 16'h8000, 16'hFFFE};
        logic         ec [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic         eo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [NIB-1:0] ecin [4] = '{4'b0000, 4'b1110, 4'b1110, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            if (i == 0) res_ready = 1'b1;
            do_op(a[i], b[i], s[i], lat, cins);
            checks++; if (lat !== NIB) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, NIB); end
            checks++; if (result !== er[i]) begin failures++; $display("FAIL dir%0d_result got=%h exp=%h", i, result, er[i]); end
            checks++; if (carry_out !== ec[i]) begin failures++; $display("FAIL dir%0d_carry got=%b exp=%b", i, carry_out, ec[i]); end
            checks++; if (overflow !== eo[i]) begin failures++; $display("FAIL dir%0d_overflow got=%b exp=%b", i, overflow, eo[i]); end
            checks++; if (cins !== ecin[i]) begin failures++; $display("FAIL dir%0d_carry_chain got=%b exp=%b", i, cins, ecin[i]); end
            release_result();
            checks++; if (res_valid !== 1'b0 || start_ready !== 1'b1) begin failures++; $display("FAIL dir%0d_release got valid=%b ready=%b exp valid=0 ready=1", i, res_valid, start_ready); end
        end
    endtask

    task automatic test_stall();
        int lat;
        logic [NIB-1:0] cins;
        do_op(16'h1357, 16'h2468, 1'b0, lat, cins);
        for (int i = 0; i < 10; i++) begin
            start_valid = 1'($urandom);
            a_in = W'($urandom); b_in = W'($urandom);
            @(posedge clk); #1;
            checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", i, res_valid); end
            checks++; if (result !== 16'h37BF) begin failures++; $display("FAIL stall_result cyc=%0d got=%h exp=37bf", i, result); end
            checks++; if (start_ready !== 1'b0) begin failures++; $display("FAIL stall_start_ready cyc=%0d got=%b exp=0", i, start_ready); end
        end
        start_valid = 1'b0;
        release_result();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || start_ready !== 1'b1) begin failures++; $display("FAIL stall_not_queued got busy=%b ready=%b exp busy=0 ready=1", busy, start_ready); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [NIB-1:0] cins;
        start_valid = 1'b1; a_in = 16'hABCD; b_in = 16'h1111; sub_in = 1'b0;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (start_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("FAIL midrst_state got ready=%b busy=%b valid=%b exp 1/0/0", start_ready, busy, res_valid); end
        checks++; if (result !== '0) begin failures++; $display("FAIL midrst_result got=%h exp=0", result); end
        checks++; if ({add_a, add_b, add_cin} !== 9'd0) begin failures++; $display("FAIL midrst_add_io got=%h/%h/%b exp=0", add_a, add_b, add_cin); end
        repeat (NIB + 2) @(posedge clk);
        #1;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL midrst_discard got=%b exp=0", res_valid); end
        do_op(16'h1234, 16'h1111, 1'b0, lat, cins);
        checks++; if (lat !== NIB || result !== 16'h2345) begin failures++; $display("FAIL midrst_next got=%h lat=%0d exp=2345 lat=%0d", result, lat, NIB); end
        release_result();
    endtask

    task automatic test_random();
        int lat;
        logic [NIB-1:0] cins;
        logic [W-1:0] a, b, er;
        logic s, ec, eo;
        int nbad;
        nbad = 0;
        for (int i = 0; i < 500; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            if (i % 7 == 0) b = ~a;
            s = 1'($urandom);
            ref_model(a, b, s, er, ec, eo);
            do_op(a, b, s, lat, cins);
            checks++;
            if (lat !== NIB || result !== er || carry_out !== ec || overflow !== eo) begin
                failures++;
                if (nbad < 10) $display("FAIL rand%0d a=%h b=%h sub=%b got=%h/%b/%b lat=%0d exp=%h/%b/%b lat=%0d",
                                        i, a, b, s, result, carry_out, overflow, lat, er, ec, eo, NIB);
                nbad++;
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            release_result();
        end
    endtask

    initial begin
        rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
        a_in = '0; b_in = '0; sub_in = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
